// File: rtl/rxfifo_pkg.sv
// Shared register map and bit positions for the UART receive FIFO peripheral.
package rxfifo_pkg;

   localparam logic [3:0] ADDR_DATA   = 4'h0;
   localparam logic [3:0] ADDR_STATUS = 4'h2;
   localparam logic [3:0] ADDR_LINES  = 4'h4;
   localparam logic [3:0] ADDR_CTRL   = 4'h6;

   localparam int unsigned ST_EMPTY      = 0;
   localparam int unsigned ST_FULL       = 1;
   localparam int unsigned ST_OVERFLOW   = 2;
   localparam int unsigned ST_LINE_READY = 3;
   localparam int unsigned ST_TIMEOUT    = 4;
   localparam int unsigned ST_COUNT_LSB  = 8;

   localparam int unsigned CTRL_FLUSH   = 0;
   localparam int unsigned CTRL_CLR_OVF = 1;
   localparam int unsigned CTRL_CLR_TMO = 2;

endpackage

// File: rtl/rxfifo_core.sv
// Circular byte store with pointers and occupancy count.
// Caller only asserts push when there is room (or a pop in the same cycle) and pop when non-empty.
module rxfifo_core #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [7:0]            wdata,
   output logic [7:0]            head_c,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full_c,
   output logic                  empty_c
);
   localparam int unsigned PW    = DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   assign empty_c = (count == '0);
   assign full_c  = (count == CW'(DEPTH));
   assign head_c  = mem[rd_ptr];

   // Storage carries no reset; contents are only meaningful below count.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/peripheral_rxfifo.sv
// UART receive FIFO on the J1 IO bus: bus decode, line counter, sticky flags.
// Optional idle timeout flag is built when RXFIFO_TIMEOUT_EN is defined.
module peripheral_rxfifo
   import rxfifo_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2     = 4,
   parameter logic [7:0]  TERM_CHAR      = 8'h0A,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd5000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        cs,
   input  logic [3:0]  addr,
   input  logic        rd,
   input  logic        wr,
   input  logic [15:0] d_in,
   output logic [15:0] d_out
);
   localparam int unsigned CW = DEPTH_LOG2 + 1;

   logic [7:0]    head_c;
   logic [CW-1:0] count;
   logic [CW-1:0] lines;
   logic          full_c, empty_c;
   logic          overflow, timeout;
   logic          wr_ctrl_c, flush_c, clr_ovf_c, pop_c, push_c, ovf_evt_c;
   logic          line_inc_c, line_dec_c;

   // Pop is suppressed when empty; a full FIFO still accepts a byte if it is also popping.
   always_comb begin
      wr_ctrl_c  = cs && wr && (addr == ADDR_CTRL);
      flush_c    = wr_ctrl_c && d_in[CTRL_FLUSH];
      clr_ovf_c  = wr_ctrl_c && d_in[CTRL_CLR_OVF];
      pop_c      = cs && rd && (addr == ADDR_DATA) && !empty_c;
      push_c     = rx_valid && !flush_c && (!full_c || pop_c);
      ovf_evt_c  = rx_valid && !flush_c && full_c && !pop_c;
      line_inc_c = push_c && (rx_data == TERM_CHAR);
      line_dec_c = pop_c && (head_c == TERM_CHAR);
   end

   rxfifo_core #(.DEPTH_LOG2(DEPTH_LOG2)) u_core (
      .clk     (clk),
      .rst     (rst),
      .push    (push_c),
      .pop     (pop_c),
      .flush   (flush_c),
      .wdata   (rx_data),
      .head_c  (head_c),
      .count   (count),
      .full_c  (full_c),
      .empty_c (empty_c)
   );

   always_ff @(posedge clk) begin
      if (rst || flush_c)              lines <= '0;
      else if (line_inc_c && !line_dec_c) lines <= lines + CW'(1);
      else if (line_dec_c && !line_inc_c) lines <= lines - CW'(1);
   end

   // Clearing wins over a same-cycle overflow event.
   always_ff @(posedge clk) begin
      if (rst || clr_ovf_c) overflow <= 1'b0;
      else if (ovf_evt_c)   overflow <= 1'b1;
   end

`ifdef RXFIFO_TIMEOUT_EN
   logic [15:0] idle_cnt, idle_nxt_c;
   logic        clr_tmo_c;
   logic        unused_c;

   assign clr_tmo_c = wr_ctrl_c && d_in[CTRL_CLR_TMO];
   assign unused_c  = ^d_in[15:3];

   always_comb begin
      idle_nxt_c = idle_cnt;
      if (push_c || empty_c || flush_c)      idle_nxt_c = '0;
      else if (idle_cnt != TIMEOUT_CYCLES)   idle_nxt_c = idle_cnt + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         idle_cnt <= idle_nxt_c;
         if (clr_tmo_c) timeout <= 1'b0;
         else if ((idle_nxt_c == TIMEOUT_CYCLES) && (idle_cnt != TIMEOUT_CYCLES)) timeout <= 1'b1;
      end
   end
`else
   logic unused_c;

   assign timeout  = 1'b0;
   assign unused_c = ^{d_in[15:2], TIMEOUT_CYCLES};
`endif

   // Zero-latency read mux; DATA shows the head that pops at this edge.
   always_comb begin
      d_out = '0;
      if (cs) begin
         case (addr)
            ADDR_DATA: begin
               if (!empty_c) d_out = {8'h00, head_c};
            end
            ADDR_STATUS: begin
               d_out[ST_EMPTY]          = empty_c;
               d_out[ST_FULL]           = full_c;
               d_out[ST_OVERFLOW]       = overflow;
               d_out[ST_LINE_READY]     = (lines != '0);
               d_out[ST_TIMEOUT]        = timeout;
               d_out[ST_COUNT_LSB +: 8] = 8'(count);
            end
            ADDR_LINES: d_out = 16'(lines);
            default: d_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_peripheral_rxfifo.sv
// Directed plus randomized bench for peripheral_rxfifo against a queue-based reference model.
`timescale 1ns/1ps
module tb_peripheral_rxfifo;
   import rxfifo_pkg::*;

   localparam int unsigned DEPTH = 16;
`ifdef RXFIFO_TIMEOUT_EN
   localparam logic [15:0] TMO     = 16'd10;
   localparam logic [15:0] TMO_BIT = 16'h0010;
`else
   localparam logic [15:0] TMO     = 16'd5000;
   localparam logic [15:0] TMO_BIT = 16'h0000;
`endif

   logic        clk = 1'b0;
   logic        rst, rx_valid, cs, rd, wr;
   logic [7:0]  rx_data;
   logic [3:0]  addr;
   logic [15:0] d_in, d_out;

   logic [7:0]  q[$];
   logic        m_ovf, m_tmo;
   int          m_idle;
   int          checks, errors;

   always #10 clk = ~clk;

   peripheral_rxfifo #(.DEPTH_LOG2(4), .TERM_CHAR(8'h0A), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .cs(cs),
      .addr(addr), .rd(rd), .wr(wr), .d_in(d_in), .d_out(d_out)
   );

   function automatic int lines_in_q();
      int n = 0;
      foreach (q[i]) if (q[i] == 8'h0A) n++;
      return n;
   endfunction

   function automatic logic [15:0] exp_read(input logic c, input logic [3:0] a);
      logic [15:0] r = '0;
      if (!c) return r;
      case (a)
         ADDR_DATA:   if (q.size() != 0) r = {8'h00, q[0]};
         ADDR_STATUS: begin
            r[15:8] = 8'(q.size());
            r[4]    = m_tmo;
            r[3]    = (lines_in_q() != 0);
            r[2]    = m_ovf;
            r[1]    = (q.size() == DEPTH);
            r[0]    = (q.size() == 0);
         end
         ADDR_LINES:  r = 16'(lines_in_q());
         default:     r = '0;
      endcase
      return r;
   endfunction

   // Reference behaviour of one clock edge given the inputs presented in that cycle.
   task automatic model_step(input logic c, r, w, input logic [3:0] a, input logic [15:0] din,
                             input logic rxv, input logic [7:0] rxd);
      logic pop    = c && r && (a == ADDR_DATA) && (q.size() != 0);
      logic ctl    = c && w && (a == ADDR_CTRL);
      logic fl     = ctl && din[0];
      logic pushed = 1'b0;
      logic was_empty = (q.size() == 0);
      if (fl) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (rxv) begin
            if (q.size() < DEPTH) begin q.push_back(rxd); pushed = 1'b1; end
            else m_ovf = 1'b1;
         end
      end
      if (ctl && din[1]) m_ovf = 1'b0;
`ifdef RXFIFO_TIMEOUT_EN
      if (pushed || was_empty || fl) m_idle = 0;
      else if (m_idle < int'(TMO)) begin
         m_idle++;
         if (m_idle == int'(TMO)) m_tmo = 1'b1;
      end
      if (ctl && din[2]) m_tmo = 1'b0;
`else
      if (pushed || was_empty) m_idle = 0;
`endif
   endtask

   task automatic check(input string tag, input logic [15:0] exp);
      checks++;
      assert (d_out === exp) else begin
         errors++;
         $error("FAIL %s: d_out=%h expected %h", tag, d_out, exp);
      end
   endtask

   task automatic step(input logic c, r, w, input logic [3:0] a, input logic [15:0] din,
                       input logic rxv, input logic [7:0] rxd, input string tag);
      @(negedge clk);
      cs = c; rd = r; wr = w; addr = a; d_in = din; rx_valid = rxv; rx_data = rxd;
      #1 check(tag, exp_read(c, a));
      model_step(c, r, w, a, din, rxv, rxd);
      @(posedge clk); #1;
      rd = 0; wr = 0; rx_valid = 0; d_in = '0;
   endtask

   task automatic pop_expect(input logic [15:0] v, input string tag);
      @(negedge clk);
      cs = 1; rd = 1; wr = 0; addr = ADDR_DATA; rx_valid = 0;
      #1 check(tag, v);
      model_step(1, 1, 0, ADDR_DATA, 16'h0, 0, 8'h00);
      @(posedge clk); #1;
      rd = 0;
   endtask

   task automatic check_reg(input logic [3:0] a, input string tag);
      cs = 1; rd = 0; wr = 0; addr = a;
      #1 check(tag, exp_read(1, a));
   endtask

   task automatic check_val(input logic [3:0] a, input logic [15:0] v, input string tag);
      cs = 1; rd = 0; wr = 0; addr = a;
      #1 check(tag, v);
   endtask

   task automatic push(input logic [7:0] b);
      step(0, 0, 0, ADDR_DATA, 16'h0, 1, b, "push");
   endtask

   task automatic ctrl(input logic [15:0] v, input logic rxv, input logic [7:0] b);
      step(1, 0, 1, ADDR_CTRL, v, rxv, b, "ctrl_read");
   endtask

   initial begin
      logic [7:0]  ok_str [4];
      logic        c, r, w, rxv;
      logic [3:0]  a;
      logic [15:0] din;
      logic [7:0]  rxd;
      int          k;

      checks = 0; errors = 0;
      ok_str = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
      rst = 1; rx_valid = 0; cs = 0; rd = 0; wr = 0; addr = '0; d_in = '0; rx_data = '0;
      q.delete(); m_ovf = 0; m_tmo = 0; m_idle = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // Reset state and empty DATA read
      check_val(ADDR_STATUS, 16'h0001, "reset_status");
      step(1, 1, 0, ADDR_DATA, 16'h0, 0, 8'h00, "data_empty");
      check_val(ADDR_STATUS, 16'h0001, "status_after_empty_read");

      // "OK\r\n"
      foreach (ok_str[i]) push(ok_str[i]);
      check_val(ADDR_STATUS, 16'h0408, "ok_status");
      check_val(ADDR_LINES, 16'h0001, "ok_lines");
      foreach (ok_str[i]) pop_expect({8'h00, ok_str[i]}, "ok_pop");
      check_val(ADDR_LINES, 16'h0000, "ok_lines_drained");
      check_val(ADDR_STATUS, 16'h0001, "ok_empty");

      // Overflow on 17th byte, then clear it
      for (int i = 0; i < 17; i++) push(8'h10 + 8'(i));
      check_val(ADDR_STATUS, 16'h1006, "full_overflow");
      ctrl(16'h0002, 0, 8'h00);
      check_val(ADDR_STATUS, 16'h1002, "ovf_cleared");

      // Simultaneous push and pop while full
      step(1, 1, 0, ADDR_DATA, 16'h0, 1, 8'h55, "full_pushpop_head");
      check_val(ADDR_STATUS, 16'h1002, "full_pushpop_status");
      for (int i = 0; i < 15; i++) pop_expect({8'h00, 8'h11 + 8'(i)}, "drain_order");
      pop_expect(16'h0055, "wrapped_tail");
      check_val(ADDR_STATUS, 16'h0001, "drained");

      // Flush with a terminator arriving in the same cycle
      push(8'h0A);
      for (int i = 1; i < 5; i++) push(8'(i));
      check_val(ADDR_STATUS, 16'h0508, "five_buffered");
      ctrl(16'h0001, 1, 8'h0A);
      check_val(ADDR_STATUS, 16'h0001, "flush_status");
      check_val(ADDR_LINES, 16'h0000, "flush_lines");

      // Flush keeps overflow; clear-overflow beats a same-cycle overflow
      for (int i = 0; i < 17; i++) push(8'h30 + 8'(i));
      ctrl(16'h0001, 0, 8'h00);
      check_val(ADDR_STATUS, 16'h0005, "flush_keeps_ovf");
      ctrl(16'h0002, 0, 8'h00);
      for (int i = 0; i < 16; i++) push(8'h0A);
      ctrl(16'h0002, 1, 8'h77);
      check_val(ADDR_STATUS, 16'h100A, "clear_wins");
      check_val(ADDR_LINES, 16'h0010, "lines_full");
      ctrl(16'h0001, 0, 8'h00);

      // Idle timeout
      push(8'h41);
      repeat (10) step(0, 0, 0, ADDR_DATA, 16'h0, 0, 8'h00, "idle");
      check_val(ADDR_STATUS, 16'h0100 | TMO_BIT, "timeout_set");
      push(8'h42);
      check_val(ADDR_STATUS, 16'h0200 | TMO_BIT, "timeout_sticky");
      ctrl(16'h0004, 0, 8'h00);
      check_val(ADDR_STATUS, 16'h0200, "timeout_cleared");
      ctrl(16'h0001, 0, 8'h00);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         c   = ($urandom_range(0, 19) != 0);
         k   = $urandom_range(0, 9);
         a   = (k < 5) ? ADDR_DATA : (k < 7) ? ADDR_STATUS : (k < 8) ? ADDR_LINES :
               (k < 9) ? ADDR_CTRL : 4'($urandom);
         r   = (i < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
         w   = ($urandom_range(0, 5) == 0);
         din = 16'($urandom) & ((($urandom_range(0, 7) == 0)) ? 16'hFFFF : 16'hFFFE);
         rxv = ($urandom_range(0, 1) == 1);
         rxd = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
         step(c, r, w, a, din, rxv, rxd, "rand_read");
         check_reg(ADDR_STATUS, "rand_status");
         check_reg(ADDR_LINES, "rand_lines");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
